// File: rtl/ifm_csum.sv
// ifm_csum: receive-side checksum engine for the s2mm path.
// Snoops beats written into the rx data FIFO and produces a 16-bit
// one's-complement sum of bytes from offset RxCsBegin to end of frame,
// seeded with RxCsInit, plus the frame byte count.
//
// Handshake: data_fifo_wren qualifies a beat; there is no ready, so every
// beat with wren=1 is consumed in that cycle. RxSumValid is a one-cycle
// pulse; RxSum/RxLen hold their values until the next frame completes.
//
// Pipeline: beat at cycle N -> masked partial sum at N+1 -> accumulator
// at N+2 -> RxSum/RxLen/RxSumValid at N+3. Each stage carries its own
// first-beat flag, so back-to-back frames never mix.
module ifm_csum #(
    parameter int C_LEN_WIDTH = 16
) (
    input  logic                   s2mm_clk,
    input  logic                   s2mm_resetn,
    input  logic                   data_fifo_wren,
    input  logic [72:0]            data_fifo_wdata,
    input  logic [15:0]            RxCsBegin,
    input  logic [15:0]            RxCsInit,
    output logic [15:0]            RxSum,
    output logic [C_LEN_WIDTH-1:0] RxLen,
    output logic                   RxSumValid
);

    // 16-bit one's-complement add: carry-out wraps into bit 0. One
    // re-add is enough because a+b <= 0x1FFFE, so the wrap cannot carry.
    function automatic logic [15:0] add_fold(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    // Beat fields
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;

    assign tdata = data_fifo_wdata[63:0];
    assign tkeep = data_fifo_wdata[71:64];
    assign tlast = data_fifo_wdata[72];

    // Frame tracking state
    logic                   sof;
    logic [C_LEN_WIDTH-1:0] off_q;
    logic [15:0]            begin_q;

    // Stage 0 combinational results
    logic [C_LEN_WIDTH-1:0] base;
    logic [15:0]            begin_eff;
    logic [3:0]             cnt;
    logic [63:0]            mdata;
    logic [15:0]            partial;

    // Stage 1 registers
    logic        s1_valid;
    logic        s1_sof;
    logic        s1_last;
    logic [15:0] s1_part;
    logic [3:0]  s1_cnt;
    logic [15:0] s1_init;

    // Stage 2 registers
    logic                   s2_valid;
    logic                   s2_last;
    logic [15:0]            acc;
    logic [C_LEN_WIDTH-1:0] len;

    // Stage 0: byte offsets, inclusion mask, beat byte count, masked word sum
    always_comb begin
        base      = sof ? '0 : off_q;
        begin_eff = sof ? RxCsBegin : begin_q;
        cnt       = 4'd0;
        mdata     = 64'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, tkeep[i]};
            if (tkeep[i] && ((32'(base) + 32'(i)) >= 32'(begin_eff)))
                mdata[8*i +: 8] = tdata[8*i +: 8];
        end
        // Even lane is the high byte of each network-order word
        partial = add_fold(add_fold({mdata[7:0],   mdata[15:8]},  {mdata[23:16], mdata[31:24]}),
                           add_fold({mdata[39:32], mdata[47:40]}, {mdata[55:48], mdata[63:56]}));
    end

    // Frame tracking: start-of-frame flag, running offset, sampled begin
    always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
        if (!s2mm_resetn) begin
            sof     <= 1'b1;
            off_q   <= '0;
            begin_q <= 16'd0;
        end else if (data_fifo_wren) begin
            sof   <= tlast;
            off_q <= base + C_LEN_WIDTH'(cnt);
            if (sof)
                begin_q <= RxCsBegin;
        end
    end

    // Stage 1: register the folded partial sum and per-beat flags
    always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
        if (!s2mm_resetn) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_last  <= 1'b0;
            s1_part  <= 16'd0;
            s1_cnt   <= 4'd0;
            s1_init  <= 16'd0;
        end else begin
            s1_valid <= data_fifo_wren;
            if (data_fifo_wren) begin
                s1_sof  <= sof;
                s1_last <= tlast;
                s1_part <= partial;
                s1_cnt  <= cnt;
                if (sof)
                    s1_init <= RxCsInit;
            end
        end
    end

    // Stage 2: accumulate into the frame sum and byte count
    always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
        if (!s2mm_resetn) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            acc      <= 16'd0;
            len      <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_last <= s1_last;
                acc     <= add_fold(s1_sof ? s1_init : acc, s1_part);
                len     <= s1_sof ? C_LEN_WIDTH'(s1_cnt) : len + C_LEN_WIDTH'(s1_cnt);
            end
        end
    end

    // Output: publish the result and pulse valid when a frame's last beat lands
    always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
        if (!s2mm_resetn) begin
            RxSum      <= 16'd0;
            RxLen      <= '0;
            RxSumValid <= 1'b0;
        end else begin
            RxSumValid <= s2_valid && s2_last;
            if (s2_valid && s2_last) begin
                RxSum <= acc;
                RxLen <= len;
            end
        end
    end

endmodule

// File: tb/tb_ifm_csum.sv
// Testbench for ifm_csum: directed frames with hand-computed sums.
// Expected {sum, len, cycle} entries are queued by the stimulus side and
// popped by a monitor whenever RxSumValid is seen.
module tb_ifm_csum;

    localparam int W = 64;  // {sum[15:0], len[15:0], cycle[31:0]}

    logic        clk;
    logic        resetn;
    logic        wren;
    logic [72:0] wdata;
    logic [15:0] cs_begin;
    logic [15:0] cs_init;
    logic [15:0] rx_sum;
    logic [15:0] rx_len;
    logic        rx_valid;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    ifm_csum #(.C_LEN_WIDTH(16)) dut (
        .s2mm_clk        (clk),
        .s2mm_resetn     (resetn),
        .data_fifo_wren  (wren),
        .data_fifo_wdata (wdata),
        .RxCsBegin       (cs_begin),
        .RxCsInit        (cs_init),
        .RxSum           (rx_sum),
        .RxLen           (rx_len),
        .RxSumValid      (rx_valid)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard: compare every pulse against the head of the queue
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual=sum %h len %0d required=no pulse", rx_sum, rx_len);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("rx_sum", {16'd0, rx_sum}, {16'd0, e[63:48]});
                check("rx_len", {16'd0, rx_len}, {16'd0, e[47:32]});
                check("pulse_cycle", cyc, e[31:0]);
            end
        end
    end

    // Driver tasks: called just after a posedge; return just after the next one
    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l,
                        input logic [15:0] b, input logic [15:0] ini);
        wren     = 1'b1;
        wdata    = {l, k, d};
        cs_begin = b;
        cs_init  = ini;
        @(posedge clk);
        #1;
        wren = 1'b0;
    endtask

    task automatic send_last(input logic [63:0] d, input logic [7:0] k, input logic [15:0] b,
                             input logic [15:0] ini, input logic [15:0] s, input logic [15:0] n);
        exp_q.push_back({s, n, 32'(cyc + 3)});
        send(d, k, 1'b1, b, ini);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            @(posedge clk);
            t++;
        end
        #1;
        idle(2);
    endtask

    initial begin
        resetn   = 1'b0;
        wren     = 1'b0;
        wdata    = '0;
        cs_begin = 16'd0;
        cs_init  = 16'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_sum", {16'd0, rx_sum}, 32'd0);
        check("reset_len", {16'd0, rx_len}, 32'd0);
        check("reset_valid", {31'd0, rx_valid}, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(2);

        // 1: single beat 01..08, Begin=0, Init=0
        send_last(64'h0807060504030201, 8'hFF, 16'd0, 16'h0000, 16'h1014, 16'd8);
        idle(4);

        // 2: same beat, Begin=3 then Begin=20
        send_last(64'h0807060504030201, 8'hFF, 16'd3, 16'h0000, 16'h0C12, 16'd8);
        idle(4);
        send_last(64'h0807060504030201, 8'hFF, 16'd20, 16'h0000, 16'h0000, 16'd8);
        idle(4);

        // 3: all-FF beat then single byte AB, Init=1
        send(64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b0, 16'd0, 16'h0001);
        send_last(64'h00000000000000AB, 8'h01, 16'd0, 16'h0000, 16'hAB01, 16'd9);
        idle(4);

        // 4: three single-beat frames on consecutive cycles
        send_last(64'h0807060504030201, 8'hFF, 16'd0, 16'h0000, 16'h1014, 16'd8);
        send_last(64'h8070605040302010, 8'h0F, 16'd0, 16'h1000, 16'h5060, 16'd4);
        send_last(64'h00000000_0012FFFF, 8'h07, 16'd1, 16'h0002, 16'h1301, 16'd3);
        idle(5);

        // Fold boundary: 0xFFFF + 0x0001 wraps to 0x0001; empty frame keeps zero
        send_last(64'h0000000000000100, 8'h03, 16'd0, 16'hFFFF, 16'h0001, 16'd2);
        send_last(64'h0000000000000000, 8'h00, 16'd0, 16'h0000, 16'h0000, 16'd0);
        idle(5);

        // 6: gaps and Begin/Init changing mid-frame, then the same gap-free
        send(64'h1122334455667788, 8'hFF, 1'b0, 16'd10, 16'h0100);
        idle(2);
        send(64'h0102030405060708, 8'hFF, 1'b0, 16'd0, 16'h5555);
        idle(1);
        send_last(64'h000000000000BBAA, 8'h03, 16'd0, 16'h5555, 16'hB7C4, 16'd18);
        idle(5);
        send(64'h1122334455667788, 8'hFF, 1'b0, 16'd10, 16'h0100);
        send(64'h0102030405060708, 8'hFF, 1'b0, 16'd0, 16'h5555);
        send_last(64'h000000000000BBAA, 8'h03, 16'd0, 16'h5555, 16'hB7C4, 16'd18);
        drain();

        // 5: reset in the middle of a 4-beat frame, then the test-1 frame
        send(64'hA1A2A3A4A5A6A7A8, 8'hFF, 1'b0, 16'd0, 16'h1234);
        send(64'hB1B2B3B4B5B6B7B8, 8'hFF, 1'b0, 16'd0, 16'h1234);
        send(64'hC1C2C3C4C5C6C7C8, 8'hFF, 1'b0, 16'd0, 16'h1234);
        resetn = 1'b0;
        @(negedge clk);
        check("midreset_sum", {16'd0, rx_sum}, 32'd0);
        check("midreset_len", {16'd0, rx_len}, 32'd0);
        check("midreset_valid", {31'd0, rx_valid}, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(4);
        send_last(64'h0807060504030201, 8'hFF, 16'd0, 16'h0000, 16'h1014, 16'd8);
        drain();

        // Every queued frame must have been reported
        check("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
